// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule expander: loads M0..M15, then streams W0..W63
// from a 16-word sliding window, one word per accepted output beat.
module sha256_msg_schedule (
   input  logic        CLK,
   input  logic        RST,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        w_valid,
   input  logic        w_ready,
   output logic [31:0] w_data,
   output logic [5:0]  w_idx,
   output logic        block_done
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [5:0]  t_q, t_d;
   logic [31:0] win_q [16];
   logic [31:0] win_d [16];
   logic        done_q, done_d;
   logic        load_beat;
   logic        out_beat;

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
   endfunction

   assign in_ready   = (state_q != RUN);
   assign w_valid    = (state_q == RUN);
   assign w_data     = w_valid ? win_q[0] : 32'd0;
   assign w_idx      = t_q;
   assign block_done = done_q;
   assign load_beat  = in_valid & in_ready;
   assign out_beat   = w_valid & w_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      t_d     = t_q;
      win_d   = win_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE, LOAD: begin
            // cnt_q is always 0 in IDLE, so both states share one write path
            if (load_beat) begin
               win_d[cnt_q] = in_data;
               cnt_d        = cnt_q + 4'd1;
               if (cnt_q == 4'd15) begin
                  state_d = RUN;
                  t_d     = 6'd0;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         RUN: begin
            if (out_beat) begin
               for (int i = 0; i < 15; i++) begin
                  win_d[i] = win_q[i+1];
               end
               win_d[15] = sig1(win_q[14]) + win_q[9]
                         + sig0(win_q[1]) + win_q[0];
               t_d = t_q + 6'd1;
               if (t_q == 6'd63) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         t_q     <= 6'd0;
         done_q  <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            win_q[i] <= 32'd0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         t_q     <= t_d;
         done_q  <= done_d;
         for (int i = 0; i < 16; i++) begin
            win_q[i] <= win_d[i];
         end
      end
   end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Randomized self-checking bench for sha256_msg_schedule against a
// FIPS 180-4 message schedule model.
module tb_sha256_msg_schedule;

   typedef logic [31:0] blk_t [16];
   typedef logic [31:0] sched_t [64];

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = 32'd0;
   logic        w_valid;
   logic        w_ready = 1'b0;
   logic [31:0] w_data;
   logic [5:0]  w_idx;
   logic        block_done;

   int total = 0;
   int bad = 0;

   sha256_msg_schedule dut (
      .CLK        (CLK),
      .RST        (RST),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .w_valid    (w_valid),
      .w_ready    (w_ready),
      .w_data     (w_data),
      .w_idx      (w_idx),
      .block_done (block_done)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic sched_t golden(input blk_t m);
      sched_t w;
      for (int t = 0; t < 64; t++) begin
         if (t < 16) w[t] = m[t];
         else w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10))
                   + w[t-7]
                   + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3))
                   + w[t-16];
      end
      return w;
   endfunction

   function automatic blk_t abc_block();
      blk_t m;
      for (int i = 0; i < 16; i++) m[i] = 32'd0;
      m[0]  = 32'h61626380;
      m[15] = 32'h00000018;
      return m;
   endfunction

   function automatic blk_t rand_block();
      blk_t m;
      for (int i = 0; i < 16; i++) m[i] = $urandom;
      return m;
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Drives one block; returns cycles used, whether w_valid was ever seen
   // during the load, and a timeout flag.
   task automatic load_block(input blk_t m, input int gap_pct,
                             output int ncyc, output int wv_seen,
                             output int tmo);
      int  i;
      bit  acc;
      i = 0; ncyc = 0; wv_seen = 0; tmo = 0;
      while (i < 16 && ncyc < 400) begin
         in_valid = (gap_pct == 0) ? 1'b1 : ($urandom_range(99) >= gap_pct);
         in_data  = in_valid ? m[i] : $urandom;
         acc = in_valid && in_ready;
         if (w_valid) wv_seen++;
         step();
         ncyc++;
         if (acc) i++;
      end
      in_valid = 1'b0;
      in_data  = $urandom;
      if (i < 16) tmo = 1;
   endtask

   // mode 0: w_ready=1; mode 1: stalls 3 cycles at t=20, 1 at t=63;
   // mode 2: random w_ready. noise drives junk in_valid during RUN.
   // Returns at the sample point of the cycle after W63 is consumed.
   task automatic drain(input int mode, input bit noise,
                        output sched_t got, output int n,
                        output int idx_bad, output int hold_bad,
                        output int early_done, output int cycles,
                        output logic done_now, output logic wv_after,
                        output logic ir_after);
      int          s20, s63;
      logic [31:0] pd;
      logic [5:0]  pi;
      bit          stalled;
      n = 0; idx_bad = 0; hold_bad = 0; early_done = 0; cycles = 0;
      s20 = 0; s63 = 0;
      for (int k = 0; k < 64; k++) got[k] = 32'hx;
      while (n < 64 && cycles < 600) begin
         if (block_done) early_done++;
         case (mode)
            1: begin
               w_ready = 1'b1;
               if (w_idx == 6'd20 && s20 < 3) begin w_ready = 1'b0; s20++; end
               if (w_idx == 6'd63 && s63 < 1) begin w_ready = 1'b0; s63++; end
            end
            2: w_ready = ($urandom_range(3) != 0);
            default: w_ready = 1'b1;
         endcase
         in_valid = noise ? 1'b1 : 1'b0;
         in_data  = $urandom;
         stalled  = 0;
         if (w_valid && w_ready) begin
            got[n] = w_data;
            if (w_idx !== n[5:0]) idx_bad++;
            n++;
         end else if (w_valid) begin
            stalled = 1; pd = w_data; pi = w_idx;
         end
         step();
         cycles++;
         if (stalled && (!w_valid || w_data !== pd || w_idx !== pi))
            hold_bad++;
      end
      in_valid = 1'b0;
      w_ready  = 1'b0;
      done_now = block_done;
      wv_after = w_valid;
      ir_after = in_ready;
   endtask

   task automatic test_reset();
      blk_t   m;
      sched_t exp, got;
      int     nc, wv, tmo, n, ib, hb, ed, cy;
      logic   dn, wa, ia;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
      total++; if (w_valid !== 1'b0) begin bad++; $display("FAIL rst_w_valid got=%b exp=0", w_valid); end
      total++; if (w_idx !== 6'd0) begin bad++; $display("FAIL rst_w_idx got=%0d exp=0", w_idx); end
      total++; if (w_data !== 32'd0) begin bad++; $display("FAIL rst_w_data got=%h exp=0", w_data); end
      total++; if (block_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", block_done); end
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1; in_data = $urandom; step();
      end
      in_valid = 1'b0;
      RST = 1'b1; step(); RST = 1'b0;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
      total++; if (w_valid !== 1'b0) begin bad++; $display("FAIL midrst_w_valid got=%b exp=0", w_valid); end
      total++; if (w_idx !== 6'd0) begin bad++; $display("FAIL midrst_w_idx got=%0d exp=0", w_idx); end
      m = rand_block();
      exp = golden(m);
      load_block(m, 0, nc, wv, tmo);
      total++; if (tmo !== 0 || nc !== 16) begin bad++; $display("FAIL midrst_load cycles=%0d exp=16", nc); end
      total++; if (w_valid !== 1'b1 || w_idx !== 6'd0) begin bad++; $display("FAIL midrst_start valid=%b idx=%0d exp 1/0", w_valid, w_idx); end
      drain(0, 1'b0, got, n, ib, hb, ed, cy, dn, wa, ia);
      for (int t = 0; t < 64; t++) begin
         total++; if (got[t] !== exp[t]) begin bad++; $display("FAIL midrst_W%0d got=%h exp=%h", t, got[t], exp[t]); end
      end
      step();
   endtask

   task automatic test_abc(input int mode);
      blk_t   m;
      sched_t exp, got;
      int     nc, wv, tmo, n, ib, hb, ed, cy;
      logic   dn, wa, ia;
      m = abc_block();
      exp = golden(m);
      load_block(m, 0, nc, wv, tmo);
      total++; if (tmo !== 0 || wv !== 0) begin bad++; $display("FAIL abc_load tmo=%0d wvalid_seen=%0d exp 0/0", tmo, wv); end
      total++; if (w_valid !== 1'b1 || w_idx !== 6'd0) begin bad++; $display("FAIL abc_rise valid=%b idx=%0d exp 1/0", w_valid, w_idx); end
      drain(mode, 1'b1, got, n, ib, hb, ed, cy, dn, wa, ia);
      total++; if (got[0] !== 32'h61626380) begin bad++; $display("FAIL abc_W0 got=%h exp=61626380", got[0]); end
      total++; if (got[15] !== 32'h00000018) begin bad++; $display("FAIL abc_W15 got=%h exp=00000018", got[15]); end
      total++; if (got[16] !== 32'h61626380) begin bad++; $display("FAIL abc_W16 got=%h exp=61626380", got[16]); end
      total++; if (got[17] !== 32'h000F0000) begin bad++; $display("FAIL abc_W17 got=%h exp=000F0000", got[17]); end
      total++; if (got[18] !== 32'h7DA86405) begin bad++; $display("FAIL abc_W18 got=%h exp=7DA86405", got[18]); end
      total++; if (got[63] !== 32'h12B1EDEB) begin bad++; $display("FAIL abc_W63 got=%h exp=12B1EDEB", got[63]); end
      for (int t = 0; t < 64; t++) begin
         total++; if (got[t] !== exp[t]) begin bad++; $display("FAIL abc_m%0d_W%0d got=%h exp=%h", mode, t, got[t], exp[t]); end
      end
      total++; if (ib !== 0) begin bad++; $display("FAIL abc_idx errors=%0d exp=0", ib); end
      total++; if (hb !== 0) begin bad++; $display("FAIL abc_hold errors=%0d exp=0", hb); end
      total++; if (ed !== 0) begin bad++; $display("FAIL abc_early_done count=%0d exp=0", ed); end
      total++; if (cy !== (mode == 1 ? 68 : 64)) begin bad++; $display("FAIL abc_cycles got=%0d exp=%0d", cy, mode == 1 ? 68 : 64); end
      total++; if (dn !== 1'b1) begin bad++; $display("FAIL abc_done got=%b exp=1", dn); end
      total++; if (wa !== 1'b0 || ia !== 1'b1) begin bad++; $display("FAIL abc_after valid=%b ready=%b exp 0/1", wa, ia); end
      step();
      total++; if (block_done !== 1'b0) begin bad++; $display("FAIL abc_done_pulse got=%b exp=0", block_done); end
   endtask

   task automatic test_input_gaps();
      blk_t   m;
      sched_t exp, got;
      int     nc, wv, tmo, n, ib, hb, ed, cy;
      logic   dn, wa, ia;
      m = abc_block();
      exp = golden(m);
      load_block(m, 40, nc, wv, tmo);
      total++; if (tmo !== 0 || wv !== 0) begin bad++; $display("FAIL gaps_load tmo=%0d wvalid_seen=%0d exp 0/0", tmo, wv); end
      drain(0, 1'b0, got, n, ib, hb, ed, cy, dn, wa, ia);
      for (int t = 0; t < 64; t++) begin
         total++; if (got[t] !== exp[t]) begin bad++; $display("FAIL gaps_W%0d got=%h exp=%h", t, got[t], exp[t]); end
      end
      total++; if (dn !== 1'b1) begin bad++; $display("FAIL gaps_done got=%b exp=1", dn); end
      step();
   endtask

   task automatic test_back_to_back();
      blk_t   ma, mb;
      sched_t exp, got;
      int     nc, wv, tmo, n, ib, hb, ed, cy;
      logic   dn, wa, ia;
      ma = rand_block();
      mb = rand_block();
      load_block(ma, 0, nc, wv, tmo);
      drain(0, 1'b0, got, n, ib, hb, ed, cy, dn, wa, ia);
      total++; if (dn !== 1'b1 || ia !== 1'b1) begin bad++; $display("FAIL b2b_done done=%b ready=%b exp 1/1", dn, ia); end
      exp = golden(mb);
      load_block(mb, 0, nc, wv, tmo);
      total++; if (tmo !== 0 || nc !== 16) begin bad++; $display("FAIL b2b_load cycles=%0d exp=16", nc); end
      total++; if (w_valid !== 1'b1 || w_idx !== 6'd0) begin bad++; $display("FAIL b2b_rise valid=%b idx=%0d exp 1/0", w_valid, w_idx); end
      drain(2, 1'b1, got, n, ib, hb, ed, cy, dn, wa, ia);
      for (int t = 0; t < 64; t++) begin
         total++; if (got[t] !== exp[t]) begin bad++; $display("FAIL b2b_W%0d got=%h exp=%h", t, got[t], exp[t]); end
      end
      total++; if (ib !== 0 || hb !== 0) begin bad++; $display("FAIL b2b_idx_hold idx=%0d hold=%0d exp 0/0", ib, hb); end
      total++; if (dn !== 1'b1) begin bad++; $display("FAIL b2b_done2 got=%b exp=1", dn); end
      step();
   endtask

   task automatic test_all_ones();
      blk_t   m;
      sched_t exp, got;
      int     nc, wv, tmo, n, ib, hb, ed, cy;
      logic   dn, wa, ia;
      for (int i = 0; i < 16; i++) m[i] = 32'hFFFFFFFF;
      exp = golden(m);
      load_block(m, 20, nc, wv, tmo);
      drain(2, 1'b0, got, n, ib, hb, ed, cy, dn, wa, ia);
      for (int t = 16; t < 64; t++) begin
         total++; if (got[t] !== exp[t]) begin bad++; $display("FAIL ones_W%0d got=%h exp=%h", t, got[t], exp[t]); end
      end
      total++; if (hb !== 0) begin bad++; $display("FAIL ones_hold errors=%0d exp=0", hb); end
      total++; if (dn !== 1'b1) begin bad++; $display("FAIL ones_done got=%b exp=1", dn); end
      step();
   endtask

   initial begin
      RST = 1'b1;
      step();
      step();
      RST = 1'b0;
      test_reset();
      test_abc(0);
      test_abc(1);
      test_input_gaps();
      test_back_to_back();
      test_all_ones();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sha256_msg_schedule.md
Name: sha256_msg_schedule

Overview:
Message-schedule expander for the SHA-256 core. Accepts one 512-bit block as 16 big-endian 32-bit words, then produces W0..W63 one word per accepted beat for the round datapath and its W holding registers. A 16-entry sliding window computes W16..W63 on the fly; nothing beyond the window is stored.

Parameters:
None. Word width (32), window depth (16) and round count (64) are fixed by FIPS 180-4.

Ports:
CLK  input  1  system clock; all state updates on rising edge
RST  input  1  synchronous reset, active-high
in_valid  input  1  in_data holds a message word
in_ready  output  1  block can accept a word this cycle
in_data  input  32  message word M_t, t = 0..15 in order
w_valid  output  1  w_data holds schedule word W_t
w_ready  input  1  round datapath consumes W_t this cycle
w_data  output  32  schedule word W_t
w_idx  output  6  index t of the word on w_data
block_done  output  1  one-cycle pulse: W63 consumed

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high. It is sampled only on the CLK rising edge.
- Reset (RST=1 at an edge):
  - state goes to IDLE; load counter and round counter go to 0.
  - All 16 window entries are cleared to 0.
  - Outputs: w_valid=0, w_data=0, w_idx=0, block_done=0, in_ready=1.
  - Reset overrides everything, including mid-LOAD or mid-RUN. The partial block is discarded.
- States: IDLE, LOAD, RUN.
- in_ready is 1 in IDLE and LOAD and 0 in RUN. It is decoded from state only.
- Load beats:
  - A load beat is in_valid & in_ready.
  - IDLE: a beat writes win[0] and sets the load counter to 1. State goes to LOAD.
  - LOAD: a beat writes win[cnt] and increments cnt.
  - The beat with cnt=15 writes win[15] and moves to RUN with round counter t=0.
  - in_data is ignored when in_valid=0 or in_ready=0.
- RUN:
  - w_valid=1, w_data=win[0], w_idx=t.
  - w_valid rises the cycle after the 16th load beat.
  - w_data and w_idx hold stable while w_ready=0.
- On an output beat (w_valid & w_ready):
  - Window shifts: win[i] <= win[i+1] for i = 0..14.
  - win[15] <= sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0], mod 2^32. This is W_{t+16}.
  - t increments.
  - The value shifted in for t >= 48 is never emitted and is don't-care.
- Sigma functions:
  - sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - Additions wrap at 32 bits; carries are discarded.
- Output beat at t=63:
  - block_done pulses 1 on the following cycle.
  - State goes to IDLE; w_valid=0 on that same following cycle.
  - in_ready=1, so the next block may start loading immediately (back-to-back blocks).
- Combinational paths: there is no combinational path from in_valid to w_valid or from w_ready to in_ready. w_ready only gates state and window updates.
- Throughput: 16 load cycles + 64 output cycles = 80 cycles per block minimum. Stalls on either side extend this with no data loss.
- Out-of-scope input: in_valid during RUN is ignored and must not be dropped into the window.

Test Plan:
1. Reset mid-block: load 7 words, assert RST for 1 cycle -> next cycle in_ready=1, w_valid=0, w_idx=0. A following full 16-word load restarts cleanly at W0.
2. "abc" block, w_ready tied 1: M0=0x61626380, M1..M14=0, M15=0x00000018 -> the following words appear in order:
   - W0=0x61626380, W15=0x00000018
   - W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W63=0x12B1EDEB
   - w_valid rises the cycle after the 16th beat; block_done pulses exactly once, the cycle after W63.
3. Output backpressure: same block, drop w_ready for 3 cycles at t=20 and 1 cycle at t=63 -> w_data and w_idx hold across each stall. The sequence is identical to scenario 2; block_done is delayed accordingly.
4. Input gaps: 16 words with in_valid low on random cycles -> only valid beats are stored, and the output matches scenario 2.
5. Back-to-back: the second block's first in_valid arrives in the cycle block_done pulses -> it is accepted. The second block's W sequence matches the golden model; no carry-over from block 1.
6. Wrap/width check: all-ones block (M_t=0xFFFFFFFF) -> every W16..W63 matches a software model, confirming the mod 2^32 wrap.
